// File: rtl/hash_capture.sv
// -----------------------------------------------------------------------------
// hash_capture
//
// Captures one frame of HASH_BYTES hash bytes from the design under test into
// a small buffer. The buffer is read back through a registered port, and the
// frame status is shown as an FSM state intended for the LEDs.
//
// Parameters
//   HASH_BYTES : hash bytes per frame (1..64)
//   TIMEOUT    : maximum gap cycles allowed inside a frame (1..255)
//
// Ports
//   clk        : design clock, the same domain as the design under test
//   rst_async  : asynchronous active-high reset. Its release must already be
//                synchronised to clk before it reaches this block.
//   hash_i     : hash byte from the design under test
//   hash_v_i   : hash byte valid
//   clear_i    : synchronous re-arm. It has priority over hash_v_i.
//   rd_addr_i  : readout byte address
//   rd_data_o  : buffer[rd_addr_i] one cycle later. Reads 0x00 when the
//                address is at or above HASH_BYTES.
//   state_o    : IDLE=0, CAPTURE=1, DONE=2, ERROR=3
//   count_o    : bytes captured so far (saturates at HASH_BYTES)
//   done_o     : a complete frame has been captured
//   err_o      : sticky frame error (timeout or extra byte)
//   crc_o      : CRC-8 (poly 0x07) of the stored bytes. It is 0x00 unless
//                HASH_CAPTURE_CRC_EN is defined.
//
// Build option
//   HASH_CAPTURE_CRC_EN : enables the running CRC-8 over the stored bytes.
// -----------------------------------------------------------------------------
module hash_capture #(
  parameter int HASH_BYTES = 64,
  parameter int TIMEOUT    = 200
) (
  input  logic       clk,
  input  logic       rst_async,
  input  logic [7:0] hash_i,
  input  logic       hash_v_i,
  input  logic       clear_i,
  input  logic [5:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  output logic [1:0] state_o,
  output logic [6:0] count_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] crc_o
);

  localparam logic [6:0] HB_LIM = 7'(HASH_BYTES);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2,
    ERROR   = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [6:0] count_reg, count_next;
  logic [7:0] gap_reg,   gap_next;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [6:0] count_inc;
  logic [7:0] gap_inc;

  // The buffer always has 64 entries, so the 6-bit address indexes it directly.
  // Entries at or above HASH_BYTES are never written, and the read port masks
  // them out.
  logic [7:0] mem [0:63];
  logic [7:0] rd_data_reg;

  assign count_inc = count_reg + 7'd1;
  assign gap_inc   = gap_reg + 8'd1;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_reg <= IDLE;
      count_reg <= 7'd0;
      gap_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      gap_reg   <= gap_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    gap_next   = gap_reg;
    wr_en      = 1'b0;
    wr_addr    = count_reg[5:0];
    if (clear_i) begin
      // A byte that arrives in the same cycle as clear_i is dropped.
      state_next = IDLE;
      count_next = 7'd0;
      gap_next   = 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hash_v_i) begin
            wr_en      = 1'b1;
            wr_addr    = 6'd0;
            count_next = 7'd1;
            gap_next   = 8'd0;
            state_next = (HB_LIM == 7'd1) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (hash_v_i) begin
            wr_en      = 1'b1;
            count_next = count_inc;
            gap_next   = 8'd0;
            if (count_inc == HB_LIM) begin
              state_next = DONE;
            end
          end else begin
            gap_next = gap_inc;
            if (gap_inc == TO_LIM) begin
              state_next = ERROR;
            end
          end
        end
        DONE: begin
          // An extra byte after a complete frame is an overflow. The byte is
          // not stored, and count stays at HASH_BYTES.
          if (hash_v_i) begin
            state_next = ERROR;
          end
        end
        default: begin
          // ERROR is held until clear_i.
          state_next = ERROR;
        end
      endcase
    end
  end

  // The write port is not reset, so buffer contents survive both clear and
  // reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= hash_i;
    end
  end

  // Registered read. A same-cycle write to the same address returns the old
  // data.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      rd_data_reg <= 8'h00;
    end else if ({1'b0, rd_addr_i} < HB_LIM) begin
      rd_data_reg <= mem[rd_addr_i];
    end else begin
      rd_data_reg <= 8'h00;
    end
  end

  assign rd_data_o = rd_data_reg;
  assign state_o   = state_reg;
  assign count_o   = count_reg;
  assign done_o    = (state_reg == DONE);
  assign err_o     = (state_reg == ERROR);

`ifdef HASH_CAPTURE_CRC_EN
  logic [7:0] crc_reg, crc_next;

  // One byte of CRC-8, polynomial 0x07, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] val);
    logic [7:0] c;
    c = val;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // The CRC advances only on stored bytes. Bytes dropped in DONE, in ERROR or
  // on clear leave it unchanged.
  always_comb begin
    crc_next = crc_reg;
    if (clear_i) begin
      crc_next = 8'h00;
    end else if (wr_en) begin
      crc_next = crc8_byte(crc_reg ^ hash_i);
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      crc_reg <= 8'h00;
    end else begin
      crc_reg <= crc_next;
    end
  end

  assign crc_o = crc_reg;
`else
  assign crc_o = 8'h00;
`endif

endmodule

// File: doc/hash_capture.md
HASH_CAPTURE -- requirements
Module: hash_capture

Interface
REQ-001 The module SHALL have parameter HASH_BYTES, default 64, meaning the number of hash bytes per frame (legal range 1..64).
REQ-002 The module SHALL have parameter TIMEOUT, default 200, meaning the maximum number of gap cycles allowed inside a frame (legal range 1..255).
REQ-003 The module SHALL have port clk, input, 1 bit: the design clock, the same domain as the design under test.
REQ-004 The module SHALL have port rst_async, input, 1 bit: the reset, asynchronous, active-high.
REQ-005 The module SHALL have port hash_i, input, 8 bits: the hash byte from the design under test (uo_out).
REQ-006 The module SHALL have port hash_v_i, input, 1 bit: hash byte valid (uio_out[7]).
REQ-007 The module SHALL have port clear_i, input, 1 bit: a synchronous request to re-arm capture.
REQ-008 The module SHALL have port rd_addr_i, input, 6 bits: the readout byte address.
REQ-009 The module SHALL have port rd_data_o, output, 8 bits: the captured byte at rd_addr_i.
REQ-010 The module SHALL have port state_o, output, 2 bits: the FSM state encoding, intended for the LEDs.
REQ-011 The module SHALL have port count_o, output, 7 bits: the number of bytes captured so far.
REQ-012 The module SHALL have port done_o, output, 1 bit: a complete frame has been captured.
REQ-013 The module SHALL have port err_o, output, 1 bit: a sticky frame error (timeout or overflow).
REQ-014 The module SHALL have port crc_o, output, 8 bits: the CRC-8 of the captured frame; see Configuration.

Function
REQ-015 The FSM SHALL have four states: IDLE=0, CAPTURE=1, DONE=2, ERROR=3.
REQ-016 In IDLE with hash_v_i=1, the block SHALL write hash_i to buffer[0], set count to 1, and go to CAPTURE; with HASH_BYTES=1 it SHALL go directly to DONE.
REQ-017 In CAPTURE with hash_v_i=1, the block SHALL write hash_i to buffer[count] and increment count.
REQ-018 When the increment makes count equal HASH_BYTES, the block SHALL go to DONE in the same edge, and done_o SHALL be 1 from the next cycle.
REQ-019 In CAPTURE with hash_v_i=0, the gap counter SHALL increment; any valid byte SHALL clear the gap counter.
REQ-020 When the gap counter reaches TIMEOUT, the block SHALL go to ERROR and set err_o.
REQ-021 In DONE with hash_v_i=1 (an extra byte), the block SHALL go to ERROR and set err_o, SHALL NOT write the buffer, and SHALL keep count at HASH_BYTES.
REQ-022 ERROR SHALL be held until clear_i.
REQ-023 In any state, clear_i=1 SHALL set state to IDLE, count to 0, gap counter to 0, done_o to 0, err_o to 0, and crc to 0 at the next edge.
REQ-024 clear_i SHALL take priority over a simultaneous hash_v_i, and that byte SHALL be dropped.
REQ-025 Buffer contents SHALL NOT be cleared by clear_i or by reset; only count qualifies which entries are valid.
REQ-026 rd_data_o SHALL be registered with 1-cycle latency: rd_data_o(t+1) = buffer[rd_addr_i(t)].
REQ-027 A read of an address equal to the address being written in the same cycle SHALL return the old data.
REQ-028 Reads with rd_addr_i >= HASH_BYTES SHALL return 0x00.
REQ-029 count_o SHALL saturate at HASH_BYTES and SHALL NOT wrap.
REQ-030 done_o and err_o SHALL never both be 1.

Reset
REQ-031 On rst_async=1 the block SHALL immediately force: state IDLE, count_o=0, gap counter 0, done_o=0, err_o=0, crc_o=0x00, rd_data_o=0x00.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; after release the next valid byte SHALL be stored at index 0.
REQ-033 Reset release SHALL be synchronised externally, and the block SHALL NOT re-synchronise it.

Configuration
REQ-034 Macro HASH_CAPTURE_CRC_EN SHALL control the CRC feature.
REQ-035 With HASH_CAPTURE_CRC_EN defined, each stored byte SHALL update crc = CRC8(crc ^ byte), using polynomial 0x07, MSB-first, init 0x00, no reflection and no final xor, and crc_o SHALL present the register value.
REQ-036 With HASH_CAPTURE_CRC_EN defined, bytes dropped in DONE, ERROR or on clear SHALL NOT update crc.
REQ-037 Without HASH_CAPTURE_CRC_EN, crc_o SHALL be tied to 0x00 and no CRC logic SHALL be synthesised.

Verification
REQ-038 With HASH_BYTES=64, 64 consecutive valid bytes 0x00..0x3F SHALL give done_o=1 one cycle after the last byte, count_o=64, err_o=0, and rd_addr_i=0x25 SHALL return rd_data_o=0x25 one cycle later.
REQ-039 With HASH_BYTES=2 and CRC_EN defined, bytes 0x01 then 0x00 SHALL give crc_o=0x15 and done_o=1; the single byte 0x01 alone SHALL give intermediate crc_o=0x07.
REQ-040 With 10 valid bytes, then hash_v_i low for 200 cycles, the block SHALL give state_o=3, err_o=1 and count_o=10; clear_i SHALL then give state_o=0 and count_o=0.
REQ-041 After DONE, one extra valid byte 0xAA SHALL give err_o=1, done_o=0, unchanged buffer[0] and unchanged crc_o.
REQ-042 With rst_async pulsed after 5 bytes, then 64 new bytes 0x80..0xBF, the block SHALL give done_o=1 and rd_data_o=0x80 at address 0.
REQ-043 clear_i and hash_v_i high in the same cycle while in CAPTURE SHALL give count_o=0 and state_o=0 next cycle, with the byte dropped.
